hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32I core.
- Generates per-stage enable/stall and clear/flush controls for the F/D, D/E, E/M and M/W pipeline registers, plus E-stage operand forwarding selects.
- Handles load-use stalls, taken-branch flushes, multi-cycle data-memory waits and a fence.i drain sequence.
- Keeps a free-running stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: stage stall/flush
// controls, E-stage forwarding selects, fence.i drain and a stall-cycle counter.
module hazard_ctrl #(
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             load_e,
    input  logic             pcsrc_e,
    input  logic             fence_d,
    input  logic             dmem_req_m,
    input  logic             dmem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             fence_done,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {RUN = 1'b0, DRAIN = 1'b1} state_t;

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_t           state_r;
    logic [DW-1:0]    drain_cnt_r;
    logic             fence_done_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic memwait_s, lwstall_s, fence_entry_s, drain_s;
    logic stall_f_s, stall_d_s, stall_e_s, stall_m_s;
    logic flush_d_s, flush_e_s, flush_w_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    // M-stage result has priority over W-stage; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic wm, input logic [4:0] rdw,
                                           input logic ww);
        logic [1:0] sel;
        if (wm && (rdm != 5'd0) && (rdm == rs)) begin
            sel = 2'b10;
        end else if (ww && (rdw != 5'd0) && (rdw == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding selects for both E-stage operands.
    always_comb begin
        fwd_a_s = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
        fwd_b_s = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
    end

    // Hazard detection and prioritised stage controls.
    always_comb begin
        memwait_s     = dmem_req_m && !dmem_ready;
        lwstall_s     = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
        drain_s       = (state_r == DRAIN);
        fence_entry_s = (state_r == RUN) && fence_d && !memwait_s && !pcsrc_e
                        && !lwstall_s && !fence_done_r;
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        stall_e_s = 1'b0;
        stall_m_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        flush_w_s = 1'b0;
        if (memwait_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
        end else if (pcsrc_e) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (lwstall_s || fence_entry_s || drain_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            stall_f_s = 1'b0;
            stall_d_s = 1'b0;
        end
    end

    // Fence drain state machine and registered status.
    // The counter holds the remaining drain cycles including the current one,
    // so the last DRAIN cycle is the one where it is about to reach zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= RUN;
            drain_cnt_r  <= {DW{1'b0}};
            fence_done_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (fence_entry_s) begin
                        if (DRAIN_CYC == 1) begin
                            fence_done_r <= 1'b1;
                        end else begin
                            state_r      <= DRAIN;
                            drain_cnt_r  <= DW'(DRAIN_CYC - 1);
                            fence_done_r <= 1'b0;
                        end
                    end else begin
                        fence_done_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (memwait_s) begin
                        fence_done_r <= 1'b0;
                    end else if (drain_cnt_r <= DW'(1)) begin
                        state_r      <= RUN;
                        drain_cnt_r  <= {DW{1'b0}};
                        fence_done_r <= 1'b1;
                    end else begin
                        drain_cnt_r  <= drain_cnt_r - DW'(1);
                        fence_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= RUN;
                    drain_cnt_r  <= {DW{1'b0}};
                    fence_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Free-running count of front-end stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(stall_f_s);
        end
    end

    assign stall_f    = stall_f_s;
    assign stall_d    = stall_d_s;
    assign stall_e    = stall_e_s;
    assign stall_m    = stall_m_s;
    assign flush_d    = flush_d_s;
    assign flush_e    = flush_e_s;
    assign flush_w    = flush_w_s;
    assign fwd_a_e    = fwd_a_s;
    assign fwd_b_e    = fwd_b_s;
    assign fence_done = fence_done_r;
    assign busy       = (state_r == DRAIN);
    assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expected controls.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic regwrite_m, regwrite_w, load_e, pcsrc_e, fence_d, dmem_req_m, dmem_ready;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic fence_done, busy;
    logic [31:0] stall_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int exp_cnt  = 0;

    // ctl bit order: stall_f stall_d stall_e stall_m flush_d flush_e flush_w fence_done busy
    localparam logic [8:0] IDLE  = 9'b000000000;
    localparam logic [8:0] LW    = 9'b110001000;
    localparam logic [8:0] BR    = 9'b000011000;
    localparam logic [8:0] MW    = 9'b111100100;
    localparam logic [8:0] DR    = 9'b110001001;
    localparam logic [8:0] DR_MW = 9'b111100101;
    localparam logic [8:0] DONE  = 9'b000000010;

    hazard_ctrl #(.CNT_W(32), .DRAIN_CYC(3)) dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .load_e(load_e), .pcsrc_e(pcsrc_e), .fence_d(fence_d),
        .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .fence_done(fence_done), .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic logic [8:0] ctl();
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, fence_done, busy};
    endfunction

    task automatic clear_inputs();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {regwrite_m, regwrite_w, load_e, pcsrc_e, fence_d, dmem_req_m, dmem_ready} = '0;
    endtask

    // Check the control vector in the current cycle, then advance one clock.
    task automatic cycle(input string tag, input logic [8:0] exp_ctl);
        #1;
        check(tag, 32'(ctl()), 32'(exp_ctl));
        if (exp_ctl[8]) exp_cnt++;
        @(posedge clk);
        #2;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #2;
        check("reset_ctl", 32'(ctl()), 32'(IDLE));
        check("reset_cnt", stall_cnt, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;

        cycle("idle", IDLE);
        check("idle_fwd", {28'd0, fwd_a_e, fwd_b_e}, 32'd0);

        // forwarding
        rs1_e = 5'd5; rd_m = 5'd5; regwrite_m = 1'b1; rd_w = 5'd5; regwrite_w = 1'b1;
        #1; check("fwd_a_m", 32'(fwd_a_e), 32'd2);
        rd_m = 5'd0;
        #1; check("fwd_a_w", 32'(fwd_a_e), 32'd1);
        rs2_e = 5'd0; rd_w = 5'd0;
        #1; check("fwd_b_x0", 32'(fwd_b_e), 32'd0);
        rs2_e = 5'd9; rd_w = 5'd9; rd_m = 5'd9; regwrite_m = 1'b0;
        #1; check("fwd_b_w", 32'(fwd_b_e), 32'd1);
        clear_inputs();

        // load-use
        load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        cycle("lwstall", LW);
        check("lw_cnt", stall_cnt, 32'(exp_cnt));
        pcsrc_e = 1'b1;
        cycle("lw_br", BR);
        pcsrc_e = 1'b0; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
        cycle("lw_x0", IDLE);
        check("lw_br_cnt", stall_cnt, 32'(exp_cnt));
        clear_inputs();

        // memory wait masks a branch until released
        dmem_req_m = 1'b1; pcsrc_e = 1'b1; load_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
        for (int i = 0; i < 3; i++) cycle($sformatf("memwait%0d", i), MW);
        dmem_ready = 1'b1;
        cycle("mw_release", BR);
        check("mw_cnt", stall_cnt, 32'(exp_cnt));
        check("mw_cnt_abs", stall_cnt, 32'd4);
        clear_inputs();

        // fence drain, DRAIN_CYC=3
        fence_d = 1'b1;
        cycle("fence_c0", LW);
        cycle("fence_c1", DR);
        cycle("fence_c2", DR);
        cycle("fence_done", DONE);
        fence_d = 1'b0;
        cycle("fence_after", IDLE);
        check("fence_cnt", stall_cnt, 32'(exp_cnt));

        // fence with a memory wait in its first drain cycle
        fence_d = 1'b1;
        cycle("fmw_c0", LW);
        dmem_req_m = 1'b1;
        cycle("fmw_c1", DR_MW);
        dmem_req_m = 1'b0;
        cycle("fmw_c2", DR);
        cycle("fmw_c3", DR);
        cycle("fmw_done", DONE);
        fence_d = 1'b0;
        check("fmw_cnt", stall_cnt, 32'(exp_cnt));

        // async reset in the middle of a drain
        fence_d = 1'b1;
        cycle("rst_c0", LW);
        #1; check("rst_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        check("rst_done", 32'(fence_done), 32'd0);
        clear_inputs();
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        cycle("post_rst", IDLE);
        check("post_rst_cnt", stall_cnt, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
